dot_accumulator: RTL and testbench
==================================

# dot_accumulator

Downstream stage of the 4-bit dot-product unit. Accepts a stream of signed partial dot products, one per 64-element vector chunk, and accumulates a programmable number of chunks into one output element. Then rounds, right-shifts and saturates the sum to an 8-bit activation, which it hands to the next stage over a valid/ready handshake. It keeps long inner dimensions (K = len × 64) on a single dot-product unit.

## Interface

Parameters:
- BIT_WIDTH, 4, element width of the upstream vectors
- VEC_SIZE, 64, elements per upstream chunk
- PROD_WIDTH, 2*BIT_WIDTH+$clog2(VEC_SIZE) (=14), width of incoming signed product
- ACC_WIDTH, 24, signed accumulator width; must be ≥ PROD_WIDTH
- CNT_WIDTH, 8, width of chunk-count config
- OUT_WIDTH, 8, signed output width

Ports:
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst_n  in  1  reset: asynchronous assert, active-low
- i_cfg_len  in  CNT_WIDTH  chunks per output element; sampled on first accepted beat of a group; 0 treated as 1
- i_cfg_shift  in  5  arithmetic right-shift amount; sampled with i_cfg_len
- i_valid  in  1  upstream product valid
- o_ready  out  1  block can accept a product this cycle
- i_product  in  PROD_WIDTH  signed partial dot product
- o_valid  out  1  output element valid
- i_ready  in  1  downstream accepts output
- o_data  out  OUT_WIDTH  signed requantized result
- o_acc_ovf  out  1  accumulator saturated at least once in the group of the current o_data
- o_busy  out  1  a group is in progress (state ≠ IDLE)

## Operation

- FSM states: IDLE, ACC, OUT. Reset state is IDLE.
- A beat is accepted when i_valid && o_ready.
- IDLE:
  - o_ready=1.
  - On a beat: latch len (0→1) and shift, acc = sign-extended i_product, cnt=1, clear ovf.
  - Go to OUT if len==1, else go to ACC.
- ACC:
  - o_ready=1.
  - On a beat: acc = sat(acc + sext(i_product)), cnt=cnt+1.
  - Go to OUT when the beat makes cnt==len.
  - No beat: hold.
- OUT:
  - o_ready=0, o_valid=1. o_data and o_acc_ovf are held stable.
  - On i_ready: go to IDLE.
- Accumulator add:
  - Signed ACC_WIDTH add. On signed overflow it saturates to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1), and ovf is set (sticky for the group).
- Requantize, computed combinationally from acc in OUT:
  - If shift>0: r = (acc + 2^(shift-1)) >>> shift, computed with one guard bit so the rounding add cannot overflow. If shift==0: r = acc.
  - o_data = clamp(r, -2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1).
- Cfg inputs are ignored outside the first beat of a group.

## Timing

- Reset values: o_valid=0, o_ready=1 (IDLE), o_data=0, o_acc_ovf=0, o_busy=0. Internal acc, cnt, len and shift are all cleared.
- Latency: o_valid rises the cycle after the last beat is accepted.
- Throughput: one result per len+1 cycles minimum.
- o_data is driven as 0 whenever o_valid=0.
- Upstream may hold i_valid while o_ready=0; nothing is consumed.
- Reset asserted mid-group discards the partial sum. No output is produced for that group.
- i_valid held high through OUT: the next group starts on the first cycle back in IDLE.

## Configuration

- RELU_EN defined: after clamp, negative results output 0. o_acc_ovf is unaffected.
- RELU_EN undefined: full signed range is output.

## Test plan

- Single chunk: len=1, shift=0, product=100 → o_valid next cycle, o_data=100, ovf=0.
- Rounding: len=1, shift=1:
  - product=9 → o_data=5.
  - product=-9 → o_data=-4.
  - Without RELU_EN.
- Multi-chunk saturation: len=4, shift=4, products 1000×4 → acc=4000, r=250, o_data=127.
- Backpressure: result pending, i_ready low 3 cycles with i_valid high:
  - o_data stable, o_ready=0, no beat consumed.
  - When i_ready goes high, the next group begins the following cycle.
- Accumulator overflow: ACC_WIDTH=16, len=16, shift=8, products 4096×16:
  - acc saturates at 32767 and o_acc_ovf=1.
  - o_data=127 (32767 + 128 → 128 → clamp 127).
- Reset mid-group: len=4, 2 beats accepted, pulse i_rst_n low:
  - Outputs return to reset values immediately.
  - A fresh len=1 group with product=-3, shift=0 gives o_data=-3 (with RELU_EN: 0).

Source files
------------

// File: rtl/dot_accumulator.sv
// dot_accumulator: accumulates len signed chunk products, then rounds, shifts and
// saturates the sum to an OUT_WIDTH activation. Optional macro RELU_EN zeroes negative results.
module dot_accumulator #(
  parameter int BIT_WIDTH  = 4,
  parameter int VEC_SIZE   = 64,
  parameter int PROD_WIDTH = 2 * BIT_WIDTH + $clog2(VEC_SIZE),
  parameter int ACC_WIDTH  = 24,
  parameter int CNT_WIDTH  = 8,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [CNT_WIDTH-1:0]  i_cfg_len,
  input  logic [4:0]            i_cfg_shift,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [PROD_WIDTH-1:0] i_product,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [OUT_WIDTH-1:0]  o_data,
  output logic                  o_acc_ovf,
  output logic                  o_busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam logic [CNT_WIDTH-1:0]        CNT_ONE = CNT_WIDTH'(1'b1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ~ACC_MAX;
  localparam logic signed [ACC_WIDTH:0]   RND_ONE = (ACC_WIDTH+1)'(1'b1);
  localparam logic signed [ACC_WIDTH:0]   OUT_MAX = (ACC_WIDTH+1)'((2 ** (OUT_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0]   OUT_MIN = ~OUT_MAX;

  // Saturating signed add; the extra top bit flags that saturation occurred.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic signed [ACC_WIDTH-1:0] a,
                                                 input logic signed [ACC_WIDTH-1:0] b);
    logic signed [ACC_WIDTH-1:0] s;
    s = a + b;
    if ((a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1])) begin
      return {1'b1, (a[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX)};
    end else begin
      return {1'b0, s};
    end
  endfunction

  // Round-half-up shift with one guard bit, then clamp to the output range.
  // Shifts beyond ACC_WIDTH always round to zero, so they are short-circuited.
  function automatic logic [OUT_WIDTH-1:0] requant(input logic signed [ACC_WIDTH-1:0] a,
                                                   input logic [4:0] sh);
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] r;
    ext = {a[ACC_WIDTH-1], a};
    if (sh == 5'd0) begin
      r = ext;
    end else if (32'(sh) > ACC_WIDTH) begin
      r = '0;
    end else begin
      r = (ext + (RND_ONE << (sh - 5'd1))) >>> sh;
    end
    if (r > OUT_MAX) begin
      r = OUT_MAX;
    end else if (r < OUT_MIN) begin
      r = OUT_MIN;
    end else begin
      r = r;
    end
`ifdef RELU_EN
    if (r[ACC_WIDTH]) begin
      r = '0;
    end else begin
      r = r;
    end
`endif
    return r[OUT_WIDTH-1:0];
  endfunction

  logic [1:0]                  state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]        len_q, len_d;
  logic [4:0]                  shift_q, shift_d;
  logic                        ovf_q, ovf_d;
  logic                        valid_q, valid_d;
  logic                        ready_q, ready_d;
  logic                        busy_q, busy_d;
  logic [OUT_WIDTH-1:0]        data_q, data_d;
  logic                        acc_ovf_q, acc_ovf_d;

  logic                        beat_s;
  logic signed [ACC_WIDTH-1:0] prod_ext_s;
  logic signed [ACC_WIDTH-1:0] sum_s;
  logic                        sum_ovf_s;
  logic [CNT_WIDTH-1:0]        len_in_s;
  logic [CNT_WIDTH-1:0]        cnt_inc_s;
  logic signed [ACC_WIDTH-1:0] acc_next_s;
  logic [4:0]                  shift_next_s;
  logic                        ovf_next_s;
  logic [OUT_WIDTH-1:0]        rq_s;

  assign beat_s       = i_valid && ready_q;
  assign prod_ext_s   = ACC_WIDTH'($signed(i_product));
  assign {sum_ovf_s, sum_s} = sat_add(acc_q, prod_ext_s);
  assign len_in_s     = (i_cfg_len == '0) ? CNT_ONE : i_cfg_len;
  assign cnt_inc_s    = cnt_q + CNT_ONE;
  // The first beat of a group loads rather than adds, and takes its shift from the cfg port.
  assign acc_next_s   = (state_q == ST_IDLE) ? prod_ext_s : sum_s;
  assign shift_next_s = (state_q == ST_IDLE) ? i_cfg_shift : shift_q;
  assign ovf_next_s   = (state_q == ST_IDLE) ? 1'b0 : (ovf_q | sum_ovf_s);
  assign rq_s         = requant(acc_next_s, shift_next_s);

  // Next-state and next-output logic for the IDLE/ACC/OUT group sequencer.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    shift_d   = shift_q;
    ovf_d     = ovf_q;
    valid_d   = valid_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    data_d    = data_q;
    acc_ovf_d = acc_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (beat_s) begin
          len_d   = len_in_s;
          shift_d = shift_next_s;
          acc_d   = acc_next_s;
          cnt_d   = CNT_ONE;
          ovf_d   = ovf_next_s;
          busy_d  = 1'b1;
          if (len_in_s == CNT_ONE) begin
            state_d   = ST_OUT;
            valid_d   = 1'b1;
            ready_d   = 1'b0;
            data_d    = rq_s;
            acc_ovf_d = ovf_next_s;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (beat_s) begin
          acc_d = acc_next_s;
          ovf_d = ovf_next_s;
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == len_q) begin
            state_d   = ST_OUT;
            valid_d   = 1'b1;
            ready_d   = 1'b0;
            data_d    = rq_s;
            acc_ovf_d = ovf_next_s;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_OUT: begin
        if (i_ready) begin
          state_d   = ST_IDLE;
          valid_d   = 1'b0;
          ready_d   = 1'b1;
          busy_d    = 1'b0;
          data_d    = '0;
          acc_ovf_d = 1'b0;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        valid_d   = 1'b0;
        ready_d   = 1'b1;
        busy_d    = 1'b0;
        data_d    = '0;
        acc_ovf_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partial group.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      shift_q   <= 5'd0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      data_q    <= '0;
      acc_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      shift_q   <= shift_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      data_q    <= data_d;
      acc_ovf_q <= acc_ovf_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_acc_ovf = acc_ovf_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_dot_accumulator.sv
// Self-checking bench for dot_accumulator: directed cases plus randomized groups
// compared against an arithmetic model of accumulate/round/shift/clamp.
module tb_dot_accumulator;

  localparam int AW = 16;
  localparam longint AMAX = (64'sd1 <<< (AW - 1)) - 64'sd1;
  localparam longint AMIN = -(64'sd1 <<< (AW - 1));

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_cfg_len = 8'd0;
  logic [4:0]  i_cfg_shift = 5'd0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [13:0] i_product = 14'd0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [7:0]  o_data;
  logic        o_acc_ovf;
  logic        o_busy;

  int errors = 0;
  int checks = 0;
  int prod_a [0:299];

  dot_accumulator #(.ACC_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cfg_len(i_cfg_len), .i_cfg_shift(i_cfg_shift),
    .i_valid(i_valid), .o_ready(o_ready), .i_product(i_product), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_acc_ovf(o_acc_ovf), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: sum with clamping at every step, then round-half-up shift and clamp.
  function automatic void model(input int len, input int sh, output logic [7:0] d, output logic ovf);
    longint acc;
    longint r;
    int n;
    n = (len == 0) ? 1 : len;
    acc = longint'(prod_a[0]);
    ovf = 1'b0;
    for (int i = 1; i < n; i++) begin
      acc = acc + longint'(prod_a[i]);
      if (acc > AMAX) begin acc = AMAX; ovf = 1'b1; end
      else if (acc < AMIN) begin acc = AMIN; ovf = 1'b1; end
    end
    if (sh == 0) r = acc;
    else r = (acc + (64'sd1 <<< (sh - 1))) >>> sh;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
`ifdef RELU_EN
    if (r < 0) r = 0;
`endif
    d = r[7:0];
  endfunction

  task automatic run_group(input int len, input int sh, input int hold, input bit stalls);
    int n;
    logic [7:0] exp_d;
    logic exp_o;
    n = (len == 0) ? 1 : len;
    model(len, sh, exp_d, exp_o);
    for (int i = 0; i < n; i++) begin
      if (stalls) begin
        for (int s = 0; s < 3 && $urandom_range(0, 99) < 30; s++) begin
          i_valid = 1'b0;
          @(negedge i_clk);
        end
      end
      i_valid   = 1'b1;
      i_product = 14'(prod_a[i]);
      if (i == 0) begin
        i_cfg_len   = 8'(len);
        i_cfg_shift = 5'(sh);
      end else begin
        i_cfg_len   = 8'($urandom);
        i_cfg_shift = 5'($urandom);
      end
      chk("ready_in_group", 32'(o_ready), 32'd1);
      chk("valid_in_group", 32'(o_valid), 32'd0);
      if (i > 0) chk("busy_in_group", 32'(o_busy), 32'd1);
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    chk("out_valid", 32'(o_valid), 32'd1);
    chk("out_data", 32'(o_data), 32'(exp_d));
    chk("out_ovf", 32'(o_acc_ovf), 32'(exp_o));
    chk("out_busy", 32'(o_busy), 32'd1);
    chk("out_ready", 32'(o_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge i_clk);
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_data", 32'(o_data), 32'(exp_d));
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    chk("idle_valid", 32'(o_valid), 32'd0);
    chk("idle_data", 32'(o_data), 32'd0);
    chk("idle_ready", 32'(o_ready), 32'd1);
    chk("idle_busy", 32'(o_busy), 32'd0);
  endtask

  initial begin
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic exp_ov;
    int rl;
    int len;
    int sh;

    // Reset state
    @(negedge i_clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_ovf", 32'(o_acc_ovf), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Single chunk and rounding cases
    prod_a[0] = 100;  run_group(1, 0, 0, 1'b0);
    prod_a[0] = 9;    run_group(1, 1, 0, 1'b0);
    prod_a[0] = -9;   run_group(1, 1, 0, 1'b0);
    prod_a[0] = -200; run_group(0, 0, 1, 1'b0);

    // Multi-chunk output clamp
    for (int i = 0; i < 4; i++) prod_a[i] = 1000;
    run_group(4, 4, 2, 1'b0);

    // Accumulator saturation
    for (int i = 0; i < 16; i++) prod_a[i] = 4096;
    run_group(16, 8, 0, 1'b0);
    for (int i = 0; i < 16; i++) prod_a[i] = -8192;
    run_group(16, 0, 0, 1'b1);

    // Backpressure with upstream valid held high
    prod_a[0] = 50;
    model(1, 0, exp_a, exp_ov);
    prod_a[0] = 77;
    model(1, 0, exp_b, exp_ov);
    i_valid = 1'b1; i_product = 14'd50; i_cfg_len = 8'd1; i_cfg_shift = 5'd0;
    @(negedge i_clk);
    i_product = 14'd77;
    for (int c = 0; c < 3; c++) begin
      chk("bp_ready", 32'(o_ready), 32'd0);
      chk("bp_valid", 32'(o_valid), 32'd1);
      chk("bp_data", 32'(o_data), 32'(exp_a));
      @(negedge i_clk);
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    chk("bp_release_ready", 32'(o_ready), 32'd1);
    chk("bp_release_valid", 32'(o_valid), 32'd0);
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("bp_next_valid", 32'(o_valid), 32'd1);
    chk("bp_next_data", 32'(o_data), 32'(exp_b));
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    chk("bp_done_valid", 32'(o_valid), 32'd0);

    // Reset in the middle of a group
    i_valid = 1'b1; i_product = 14'd500; i_cfg_len = 8'd4; i_cfg_shift = 5'd0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("mid_busy", 32'(o_busy), 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_ready", 32'(o_ready), 32'd1);
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_data", 32'(o_data), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    prod_a[0] = -3;
    run_group(1, 0, 0, 1'b0);

    // Randomized groups
    for (int g = 0; g < 40; g++) begin
      rl = int'($urandom_range(0, 9));
      if (rl == 0) len = 0;
      else if (rl < 7) len = int'($urandom_range(1, 6));
      else len = int'($urandom_range(7, 24));
      sh = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 31));
      for (int i = 0; i < 24; i++) begin
        if ($urandom_range(0, 3) == 0) prod_a[i] = int'($urandom_range(0, 16383)) - 8192;
        else prod_a[i] = int'($urandom_range(0, 600)) - 300;
      end
      run_group(len, sh, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
